// File: rtl/ecc_pkg.sv
// ecc_pkg
// Shared types and constants for the SECDED encoder/decoder.
//   - APB register offsets (byte offsets and PADDR[3:2] indices)
//   - ctrl_mode_t : operation mode held in CTRL[1:0]
//   - width_sel_t : codeword width select held in CODEWORD_WIDTH[1:0]
//   - data lengths carried by each codeword width
//   - state_t     : sequencing FSM states
//   - small helpers shared by the codec
package ecc_pkg;

   localparam logic [3:0] REG_OFS_CTRL  = 4'h0;
   localparam logic [3:0] REG_OFS_DATA  = 4'h4;
   localparam logic [3:0] REG_OFS_WIDTH = 4'h8;
   localparam logic [3:0] REG_OFS_NOISE = 4'hC;

   localparam logic [1:0] REG_IDX_CTRL  = 2'd0;
   localparam logic [1:0] REG_IDX_DATA  = 2'd1;
   localparam logic [1:0] REG_IDX_WIDTH = 2'd2;
   localparam logic [1:0] REG_IDX_NOISE = 2'd3;

   localparam int DATA_LEN_8  = 4;
   localparam int DATA_LEN_16 = 11;
   localparam int DATA_LEN_32 = 26;

   typedef enum logic [1:0] {
      ENCODE = 2'd0,
      DECODE = 2'd1,
      FULL   = 2'd2
   } ctrl_mode_t;

   typedef enum logic [1:0] {
      W8     = 2'd0,
      W16    = 2'd1,
      W32    = 2'd2,
      W32_HI = 2'd3
   } width_sel_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int width_bits(input width_sel_t w);
      case (w)
         W8:      return 8;
         W16:     return 16;
         default: return 32;
      endcase
   endfunction

   function automatic int data_len(input width_sel_t w);
      case (w)
         W8:      return DATA_LEN_8;
         W16:     return DATA_LEN_16;
         default: return DATA_LEN_32;
      endcase
   endfunction

   // Hamming parity positions are the powers of two.
   function automatic logic is_pow2(input int p);
      return (p > 0) && ((p & (p - 1)) == 0);
   endfunction

endpackage

// File: rtl/ecc_hamming_codec.sv
// ecc_hamming_codec
// Combinational extended-Hamming (SECDED) datapath for 8/16/32-bit codewords.
// Hamming position p (1..n-1) lives at bit p-1; bit n-1 is overall parity.
// Ports:
//   mode       : ENCODE -> result is the codeword
//                DECODE -> data_in is the received codeword
//                FULL   -> encode(data_in) ^ noise is the received codeword
//   width_sel  : codeword width (8, 16, 32)
//   data_in    : data word or received codeword
//   noise      : error pattern applied in FULL mode
//   result     : codeword or extracted (corrected) data, zero-extended
//   num_errors : 0 clean, 1 corrected, 2 uncorrectable
module ecc_hamming_codec
   import ecc_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  ctrl_mode_t            mode,
   input  width_sel_t            width_sel,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [DATA_WIDTH-1:0] noise,
   output logic [DATA_WIDTH-1:0] result,
   output logic [1:0]            num_errors
);

   localparam int SYN_W = $clog2(DATA_WIDTH);

   int                    n;
   int                    len;
   int                    d;
   logic [DATA_WIDTH-1:0] mask;
   logic [DATA_WIDTH-1:0] cw_enc;
   logic [DATA_WIDTH-1:0] cw_rx;
   logic [DATA_WIDTH-1:0] cw_fix;
   logic [DATA_WIDTH-1:0] data_ext;
   logic [SYN_W-1:0]      syn;
   logic                  par_k;
   logic                  par_all;
   logic [1:0]            errs;

   always_comb begin
      n = width_bits(width_sel);
      if (n > DATA_WIDTH) n = DATA_WIDTH;
      len = data_len(width_sel);

      mask = '0;
      for (int i = 0; i < DATA_WIDTH; i++) mask[i] = (i < n);

      // place data bits at the non-parity positions, LSB first
      cw_enc = '0;
      d = 0;
      for (int p = 1; p < DATA_WIDTH; p++) begin
         if (p < n && !is_pow2(p)) begin
            cw_enc[p-1] = data_in[d];
            d = d + 1;
         end
      end

      // parity bits are still zero here, so each sees only data bits
      par_k = 1'b0;
      for (int k = 0; k < SYN_W; k++) begin
         if ((1 << k) < n) begin
            par_k = 1'b0;
            for (int p = 1; p < DATA_WIDTH; p++) begin
               if (p < n && ((p >> k) & 1) == 1) par_k = par_k ^ cw_enc[p-1];
            end
            cw_enc[(1 << k) - 1] = par_k;
         end
      end
      cw_enc[n-1] = ^(cw_enc & mask);

      if (mode == DECODE) cw_rx = data_in & mask;
      else                cw_rx = (cw_enc ^ noise) & mask;

      syn = '0;
      for (int p = 1; p < DATA_WIDTH; p++) begin
         if (p < n && cw_rx[p-1]) syn = syn ^ SYN_W'(p);
      end
      par_all = ^cw_rx;

      // odd overall parity means a single flip; zero syndrome puts it on bit n-1,
      // which carries no data and needs no repair
      cw_fix = cw_rx;
      if (!par_all) begin
         errs = (syn == '0) ? 2'd0 : 2'd2;
      end else begin
         errs = 2'd1;
         if (syn != '0) cw_fix[int'(syn) - 1] = ~cw_fix[int'(syn) - 1];
      end

      data_ext = '0;
      d = 0;
      for (int p = 1; p < DATA_WIDTH; p++) begin
         if (p < n && !is_pow2(p) && d < len) begin
            data_ext[d] = cw_fix[p-1];
            d = d + 1;
         end
      end

      if (mode == ENCODE) begin
         result     = cw_enc;
         num_errors = 2'd0;
      end else begin
         result     = data_ext;
         num_errors = errs;
      end
   end

endmodule

// File: rtl/ecc_enc_dec_core.sv
// ecc_enc_dec_core
// APB-programmed SECDED encoder/decoder. Registers: CTRL (0x0), DATA_IN (0x4),
// CODEWORD_WIDTH (0x8), NOISE (0xC). A CTRL write of 0/1/2 in IDLE starts an
// operation; the result appears with a one-cycle operation_done.
// Ports:
//   clk, rst (async, active low)
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA : APB slave, no wait states
//   data_out       : codeword or decoded data, held until the next result
//   num_of_errors  : 0, 1 or 2 (uncorrectable)
//   operation_done : one-cycle pulse with data_out/num_of_errors valid
//
// state   | meaning
// --------+--------------------------------------------------------
// ST_IDLE | waiting for a starting CTRL write
// ST_CALC | operands snapshotted, codec evaluating, result registered
// ST_DONE | operation_done high, results valid
module ecc_enc_dec_core
   import ecc_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int AMBA_ADDR_WIDTH = 32,
   parameter int AMBA_WORD       = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       PSEL,
   input  logic                       PENABLE,
   input  logic                       PWRITE,
   input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
   input  logic [AMBA_WORD-1:0]       PWDATA,
   output logic [AMBA_WORD-1:0]       PRDATA,
   output logic [AMBA_WORD-1:0]       data_out,
   output logic [1:0]                 num_of_errors,
   output logic                       operation_done
);

   state_t                state;
   logic [1:0]            ctrl_reg;
   logic [AMBA_WORD-1:0]  data_in_reg;
   width_sel_t            width_reg;
   logic [AMBA_WORD-1:0]  noise_reg;

   ctrl_mode_t            snap_mode;
   width_sel_t            snap_width;
   logic [DATA_WIDTH-1:0] snap_data;
   logic [DATA_WIDTH-1:0] snap_noise;

   logic [DATA_WIDTH-1:0] codec_result;
   logic [1:0]            codec_errs;

   logic                  apb_wr;
   logic [1:0]            reg_idx;
   logic                  start;
   logic                  unused_paddr;

   assign apb_wr       = PSEL & PENABLE & PWRITE;
   assign reg_idx      = PADDR[3:2];
   assign unused_paddr = ^{PADDR[AMBA_ADDR_WIDTH-1:4], PADDR[1:0]};
   assign start        = apb_wr && (reg_idx == REG_IDX_CTRL) && (state == ST_IDLE) &&
                         (PWDATA[1:0] != 2'd3);

   // CTRL is frozen while an operation is in flight; the others always accept writes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_reg    <= '0;
         data_in_reg <= '0;
         width_reg   <= W8;
         noise_reg   <= '0;
      end else if (apb_wr) begin
         case (reg_idx)
            REG_IDX_CTRL:  if (state == ST_IDLE) ctrl_reg <= PWDATA[1:0];
            REG_IDX_DATA:  data_in_reg <= PWDATA;
            REG_IDX_WIDTH: width_reg <= width_sel_t'(PWDATA[1:0]);
            REG_IDX_NOISE: noise_reg <= PWDATA;
         endcase
      end
   end

   always_comb begin
      PRDATA = '0;
      if (PSEL && !PWRITE) begin
         case (reg_idx)
            REG_IDX_CTRL:  PRDATA = {{(AMBA_WORD-2){1'b0}}, ctrl_reg};
            REG_IDX_DATA:  PRDATA = data_in_reg;
            REG_IDX_WIDTH: PRDATA = {{(AMBA_WORD-2){1'b0}}, width_reg};
            REG_IDX_NOISE: PRDATA = noise_reg;
         endcase
      end
   end

   ecc_hamming_codec #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_codec (
      .mode      (snap_mode),
      .width_sel (snap_width),
      .data_in   (snap_data),
      .noise     (snap_noise),
      .result    (codec_result),
      .num_errors(codec_errs)
   );

   // mode comes from the starting CTRL write itself, not from ctrl_reg
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= ST_IDLE;
         snap_mode      <= ENCODE;
         snap_width     <= W8;
         snap_data      <= '0;
         snap_noise     <= '0;
         data_out       <= '0;
         num_of_errors  <= '0;
         operation_done <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               operation_done <= 1'b0;
               if (start) begin
                  state      <= ST_CALC;
                  snap_mode  <= ctrl_mode_t'(PWDATA[1:0]);
                  snap_width <= width_reg;
                  snap_data  <= data_in_reg[DATA_WIDTH-1:0];
                  snap_noise <= noise_reg[DATA_WIDTH-1:0];
               end
            end
            ST_CALC: begin
               state          <= ST_DONE;
               data_out       <= AMBA_WORD'(codec_result);
               num_of_errors  <= codec_errs;
               operation_done <= 1'b1;
            end
            ST_DONE: begin
               state          <= ST_IDLE;
               operation_done <= 1'b0;
            end
            default: begin
               state          <= ST_IDLE;
               operation_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ecc_enc_dec_core.sv
module tb_ecc_enc_dec_core;

   localparam logic [31:0] A_CTRL  = 32'h0;
   localparam logic [31:0] A_DATA  = 32'h4;
   localparam logic [31:0] A_WIDTH = 32'h8;
   localparam logic [31:0] A_NOISE = 32'hC;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        PSEL = 1'b0;
   logic        PENABLE = 1'b0;
   logic        PWRITE = 1'b0;
   logic [31:0] PADDR = '0;
   logic [31:0] PWDATA = '0;
   logic [31:0] PRDATA;
   logic [31:0] data_out;
   logic [1:0]  num_of_errors;
   logic        operation_done;

   int          errors = 0;
   int          checks = 0;
   int          done_cnt = 0;
   int          cnt0;
   int          lat;
   logic [31:0] rd;

   ecc_enc_dec_core dut (
      .clk           (clk),
      .rst           (rst),
      .PSEL          (PSEL),
      .PENABLE       (PENABLE),
      .PWRITE        (PWRITE),
      .PADDR         (PADDR),
      .PWDATA        (PWDATA),
      .PRDATA        (PRDATA),
      .data_out      (data_out),
      .num_of_errors (num_of_errors),
      .operation_done(operation_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (operation_done === 1'b1) done_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // returns 1 ns after the posedge that performs the write
   task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
      @(negedge clk);
      PENABLE = 1'b1;
      @(posedge clk);
      #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
      @(negedge clk);
      PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
      #1;
      data = PRDATA;
      PSEL = 1'b0;
   endtask

   // counts negedges after the start edge until operation_done; -1 on timeout
   task automatic wait_done(output int cycles);
      cycles = -1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (operation_done === 1'b1) begin
            cycles = i;
            break;
         end
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] ctrl);
      int l;
      apb_write(A_CTRL, ctrl);
      wait_done(l);
      check(tag, l, 32'd2);
   endtask

   initial begin
      // reset state
      idle(3);
      check("rst_data_out", data_out, 32'h0);
      check("rst_num_err", {30'b0, num_of_errors}, 32'h0);
      check("rst_op_done", {31'b0, operation_done}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      apb_read(A_DATA, rd);  check("rst_rd_data", rd, 32'h0);
      apb_read(A_WIDTH, rd); check("rst_rd_width", rd, 32'h0);

      // width 8 encode 0xB -> 0x55
      apb_write(A_WIDTH, 32'h0);
      apb_write(A_DATA, 32'hB);
      apb_read(A_DATA, rd); check("rd_data_0xb", rd, 32'hB);
      run_op("lat_enc8", 32'h0);
      check("enc8_data", data_out, 32'h55);
      check("enc8_err", {30'b0, num_of_errors}, 32'h0);
      idle(1);
      check("enc8_pulse_end", {31'b0, operation_done}, 32'h0);
      check("enc8_hold", data_out, 32'h55);

      // width 8 full, single flip on a data bit and on the overall bit
      apb_write(A_NOISE, 32'h04);
      run_op("lat_full8_a", 32'h2);
      check("full8_n04_data", data_out, 32'hB);
      check("full8_n04_err", {30'b0, num_of_errors}, 32'h1);
      apb_write(A_NOISE, 32'h80);
      run_op("lat_full8_b", 32'h2);
      check("full8_n80_data", data_out, 32'hB);
      check("full8_n80_err", {30'b0, num_of_errors}, 32'h1);

      // width 8 decode with two flips: detected, not corrected
      apb_write(A_DATA, 32'h56);
      run_op("lat_dec8", 32'h1);
      check("dec8_double_err", {30'b0, num_of_errors}, 32'h2);
      check("dec8_double_data", data_out, 32'hB);

      // width 16 encode of data 1: positions 1,2,3 plus overall bit 15
      apb_write(A_WIDTH, 32'h1);
      apb_write(A_DATA, 32'h1);
      run_op("lat_enc16", 32'h0);
      check("enc16_data", data_out, 32'h8007);

      // width 32
      apb_write(A_WIDTH, 32'h2);
      apb_write(A_DATA, 32'h0);
      run_op("lat_enc32_zero", 32'h0);
      check("enc32_zero_data", data_out, 32'h0);
      check("enc32_zero_err", {30'b0, num_of_errors}, 32'h0);
      apb_write(A_NOISE, 32'h8000_0000);
      run_op("lat_full32", 32'h2);
      check("full32_data", data_out, 32'h0);
      check("full32_err", {30'b0, num_of_errors}, 32'h1);
      apb_write(A_WIDTH, 32'h3);
      apb_write(A_DATA, 32'h1);
      run_op("lat_enc32_one", 32'h0);
      check("enc32_one_data", data_out, 32'h8000_0007);

      // CTRL write during CALC ignored, DATA_IN write during DONE not in flight
      apb_write(A_WIDTH, 32'h0);
      apb_write(A_DATA, 32'hB);
      apb_write(A_NOISE, 32'h0);
      idle(1);
      cnt0 = done_cnt;
      apb_write(A_CTRL, 32'h0);
      PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = A_CTRL; PWDATA = 32'h1;
      @(posedge clk); #1;
      check("busy_done_pulse", {31'b0, operation_done}, 32'h1);
      check("busy_data_at_done", data_out, 32'h55);
      PADDR = A_DATA; PWDATA = 32'h0;
      @(posedge clk); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      idle(4);
      check("busy_done_count", done_cnt - cnt0, 32'd1);
      check("busy_data_held", data_out, 32'h55);
      check("busy_err", {30'b0, num_of_errors}, 32'h0);
      apb_read(A_CTRL, rd); check("busy_ctrl_unchanged", rd, 32'h0);
      apb_read(A_DATA, rd); check("busy_data_reg_written", rd, 32'h0);

      // CTRL = 3 in IDLE: stored, no operation
      apb_write(A_CTRL, 32'h3);
      idle(6);
      check("ctrl3_no_done", done_cnt - cnt0, 32'd1);
      apb_read(A_CTRL, rd); check("ctrl3_readback", rd, 32'h3);
      check("ctrl3_hold", data_out, 32'h55);

      // reset during CALC
      apb_write(A_DATA, 32'h1);
      apb_write(A_NOISE, 32'h5A);
      idle(1);
      cnt0 = done_cnt;
      apb_write(A_CTRL, 32'h0);
      rst = 1'b0;
      idle(3);
      check("abort_op_done", {31'b0, operation_done}, 32'h0);
      rst = 1'b1;
      idle(5);
      check("abort_no_pulse", done_cnt - cnt0, 32'd0);
      check("abort_data_out", data_out, 32'h0);
      check("abort_num_err", {30'b0, num_of_errors}, 32'h0);
      apb_read(A_CTRL, rd);  check("abort_rd_ctrl", rd, 32'h0);
      apb_read(A_DATA, rd);  check("abort_rd_data", rd, 32'h0);
      apb_read(A_WIDTH, rd); check("abort_rd_width", rd, 32'h0);
      apb_read(A_NOISE, rd); check("abort_rd_noise", rd, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ecc_enc_dec_core.md
Name: ecc_enc_dec_core

Overview:
APB-programmed extended-Hamming (SECDED) encoder/decoder. It is the DUT that directly feeds the verification checker: it produces data_out, num_of_errors and a one-cycle operation_done per operation. Codeword width is selectable: 8, 16 or 32 bits. Modes are encode, decode, or full channel (encode, XOR noise, decode).

Parameters:
DATA_WIDTH, 32, width of the internal data/codeword datapath.
AMBA_ADDR_WIDTH, 32, width of PADDR.
AMBA_WORD, 32, width of PWDATA, PRDATA and data_out.

Ports:
clk  in  1  single clock; all state changes on posedge.
rst  in  1  asynchronous, active-low reset.
PSEL  in  1  APB select.
PENABLE  in  1  APB access phase.
PWRITE  in  1  APB direction; 1 = write.
PADDR  in  AMBA_ADDR_WIDTH  byte address; only PADDR[3:2] is decoded.
PWDATA  in  AMBA_WORD  write data.
PRDATA  out  AMBA_WORD  read data.
data_out  out  AMBA_WORD  result (codeword or decoded data), zero-extended.
num_of_errors  out  2  0, 1, or 2 (2 = uncorrectable).
operation_done  out  1  one-cycle pulse; data_out and num_of_errors are valid in that cycle.

Behaviour:
- Registers (offsets):
  - CTRL 0x0 [1:0]: 0 encode, 1 decode, 2 full.
  - DATA_IN 0x4.
  - CODEWORD_WIDTH 0x8 [1:0]: 0 -> 8, 1 -> 16, 2 or 3 -> 32.
  - NOISE 0xC.
  - All registers reset to 0.
- APB write: takes effect at the posedge where PSEL & PENABLE & PWRITE are all high. There is no wait state.
- APB read: PRDATA is combinational from the addressed register when PSEL & !PWRITE. Otherwise PRDATA is 0.
- Start: an APB write to CTRL with PWDATA[1:0] != 3, while in IDLE, is the start.
  - A CTRL write with value 3 updates the register but does not start.
  - A CTRL write while busy is ignored entirely.
- State machine:
  - IDLE -> CALC on start. DATA_IN, NOISE, width and mode are snapshotted at this edge.
  - CALC -> DONE. The result is registered into data_out and num_of_errors.
  - DONE -> IDLE. operation_done = 1 in DONE only.
  - Latency: operation_done is high in the 2nd cycle after the start edge.
- Register writes during CALC/DONE update the registers but not the in-flight operation.
- Codeword layout for width n:
  - Hamming positions 1..n-1 are stored at bit p-1.
  - Parity bits sit at powers of two.
  - Data bits fill the remaining positions in ascending order from DATA_IN[0].
  - Data lengths: 4, 11 or 26 bits.
  - Parity at position 2^k = XOR of all positions with bit k set.
  - Bit n-1 is the overall parity, making the whole codeword even parity.
  - DATA_IN bits above the data length are ignored.
- Encode: data_out = codeword, zero-extended; num_of_errors = 0.
- Decode of codeword c (DATA_IN in decode mode; encode(DATA_IN) ^ NOISE[n-1:0] in full mode):
  - S = syndrome over positions 1..n-1; P = XOR of all n bits.
  - S=0, P=0: num_of_errors = 0.
  - P=1: num_of_errors = 1. Flip position S if S != 0; if S = 0 the error is in the overall bit.
  - P=0, S!=0: num_of_errors = 2. No correction.
  - data_out = the extracted data bits of the (corrected) codeword, zero-extended.
- Output holding: data_out and num_of_errors hold their value until the next DONE-producing CALC, or reset.
- Reset (any time, including mid-operation):
  - FSM returns to IDLE; all registers, data_out, num_of_errors and operation_done go to 0.
  - No operation_done is emitted for the aborted operation.

Decomposition:
- Package ecc_pkg holds:
  - register offsets;
  - ctrl_mode_t enum (ENCODE, DECODE, FULL);
  - width_sel_t enum;
  - data-length constants 4/11/26;
  - the FSM state enum.
- Sub-module ecc_hamming_codec: combinational encode, syndrome, correct and extract, selected by width.
- The top level holds the APB register file, the FSM and the output registers.

Test Plan:
- Width 8, encode, DATA_IN = 0xB -> data_out = 0x55, num_of_errors = 0. operation_done is exactly 2 cycles after the CTRL write.
- Width 8, full, DATA_IN = 0xB, NOISE = 0x04 -> data_out = 0xB, num_of_errors = 1. Repeat with NOISE = 0x80 -> data_out = 0xB, num_of_errors = 1.
- Width 8, decode, DATA_IN = 0x56 (two bit flips of 0x55) -> num_of_errors = 2.
- Width 32, encode, DATA_IN = 0 -> data_out = 0. Full mode with NOISE = 0x8000_0000 -> data_out = 0, num_of_errors = 1.
- CTRL written again during CALC, and CTRL = 3 written while in IDLE -> exactly one operation_done; result is from the original operands.
- rst asserted in CALC -> operation_done never pulses; data_out = 0; PRDATA for all registers = 0.
